mem_stage_lsu: RTL

- Parametrised successor of the single-cycle memory pipeline stage.
- Sits between execute/MEM latch and WB latch; drives a variable-latency data-memory port with req/gnt/rvalid handshake instead of a zero-latency memory file.
- Stalls the pipeline while an access is in flight; performs byte-lane steering, sign/zero extension, size-aware misalignment detection, access timeout, and clean abort on context switch.

---
 rtl/lsu_pkg.sv | 61 ++++++
 rtl/lsu_lane_align.sv | 42 ++++
 rtl/mem_stage_lsu.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: FSM state codes,
// access-size encodings, control-store bit positions and lane helpers.
package lsu_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  localparam int CST_ACC     = 0;
  localparam int CST_RES_MUX = 1;
  localparam int CST_SIZE_LO = 2;
  localparam int CST_SIZE_HI = 3;
  localparam int CST_UNS     = 4;
  localparam int CST_R_W     = 5;

  // A doubleword access on a 32-bit datapath degrades to a word access.
  function automatic size_e eff_size(input logic [1:0] sz, input int xlen);
    if (xlen == 32 && sz == 2'd3) return SZ_W;
    return size_e'(sz);
  endfunction

  // Byte-enable pattern of an access starting at lane 0.
  function automatic logic [7:0] be_mask(input size_e sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input size_e sz);
    case (sz)
      SZ_B:    return 3'd0;
      SZ_H:    return 3'd1;
      SZ_W:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  // Sign- or zero-extend the low bytes of a right-justified load value.
  function automatic logic [63:0] extend(input logic [63:0] d, input size_e sz, input logic uns);
    case (sz)
      SZ_B:    return uns ? {56'b0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
      SZ_H:    return uns ? {48'b0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      SZ_W:    return uns ? {32'b0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: byte enables, store-data replication,
// load extraction with extension, and the misalignment flag.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]                  size,
  input  logic                        uns,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic [XLEN-1:0]             store_data,
  input  logic [XLEN-1:0]             rdata,
  output logic [XLEN/8-1:0]           be,
  output logic [XLEN-1:0]             wdata,
  output logic [XLEN-1:0]             load_data,
  output logic                        mis
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  size_e       sz;
  logic [2:0]  am;
  logic [XLEN-1:0] shifted;
  logic [63:0] ext;

  // Decode the access size, then derive lanes for both directions.
  always_comb begin
    sz      = eff_size(size, XLEN);
    am      = align_mask(sz);
    mis     = |(off & am[OFF_W-1:0]);
    be      = NB'(be_mask(sz)) << off;
    wdata   = '0;
    for (int i = 0; i < NB; i++) begin
      wdata[i*8 +: 8] = store_data[(i & int'(am))*8 +: 8];
    end
    shifted   = rdata >> {off, 3'b000};
    ext       = extend(64'(shifted), sz, uns);
    load_data = ext[XLEN-1:0];
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage driving a req/gnt/rvalid data-memory port. Holds the
// pipeline while an access is outstanding, times out stuck accesses and
// drains a granted access that was squashed by a context switch.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int CST_W   = 19,
  parameter int TIMEOUT = 255,
  parameter int TMO_W   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MEM_V,
  input  logic [CST_W-1:0]  MEM_Cst,
  input  logic [XLEN-1:0]   MEM_RES,
  input  logic [XLEN-1:0]   MEM_Address,
  input  logic [31:0]       MEM_IR,
  input  logic [XLEN-1:0]   MEM_NPC,
  input  logic [XLEN-1:0]   MEM_Target_Address,
  input  logic              MEM_PC_MUX,
  input  logic              DE_Context_Switch,
  input  logic              DMEM_GNT,
  input  logic              DMEM_RVALID,
  input  logic [XLEN-1:0]   DMEM_RDATA,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [XLEN-1:0]   DMEM_ADDR,
  output logic [XLEN-1:0]   DMEM_WDATA,
  output logic [XLEN/8-1:0] DMEM_BE,
  output logic              MEM_STALL,
  output logic              V_MEM_FE_BR_STALL,
  output logic              LAM,
  output logic              SAM,
  output logic              BUS_ERR,
  output logic              WB_V,
  output logic              WB_PC_MUX,
  output logic [CST_W-1:0]  WB_Cst,
  output logic [XLEN-1:0]   WB_RES,
  output logic [XLEN-1:0]   WB_NPC,
  output logic [XLEN-1:0]   WB_Target_Address,
  output logic [31:0]       WB_IR,
  output logic [4:0]        MEM_DR
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  logic              mem_acc, mem_r_w;
  logic [NB-1:0]     be_c;
  logic [XLEN-1:0]   wdata_c, load_ext, load_val;
  logic              mis, acc_go;
  logic [2:0]        state, state_nxt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_hit, cap_rdata, cap_zero, bus_err_c;
  logic [XLEN-1:0]   rdata_q, addr_q, wdata_q;
  logic [NB-1:0]     be_q;
  logic              we_q;
  logic [4:0]        opcode;

  assign mem_acc = MEM_Cst[CST_ACC];
  assign mem_r_w = MEM_Cst[CST_R_W];
  assign opcode  = MEM_IR[6:2];

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .size       (MEM_Cst[CST_SIZE_HI:CST_SIZE_LO]),
    .uns        (MEM_Cst[CST_UNS]),
    .off        (MEM_Address[OFF_W-1:0]),
    .store_data (MEM_RES),
    .rdata      (rdata_q),
    .be         (be_c),
    .wdata      (wdata_c),
    .load_data  (load_ext),
    .mis        (mis)
  );

  assign LAM    = MEM_V & mem_acc & ~mem_r_w & mis;
  assign SAM    = MEM_V & mem_acc &  mem_r_w & mis;
  assign acc_go = MEM_V & mem_acc & ~mis & ~DE_Context_Switch;

  assign MEM_STALL         = (acc_go & (state != ST_DONE)) | (state == ST_DRAIN);
  assign V_MEM_FE_BR_STALL = MEM_V & ((opcode == 5'b11000) | (opcode == 5'b11001) | (opcode == 5'b11011));
  assign MEM_DR            = MEM_IR[11:7];

  assign DMEM_REQ   = (state == ST_REQ);
  assign DMEM_WE    = (state == ST_REQ) & we_q;
  assign DMEM_ADDR  = addr_q;
  assign DMEM_WDATA = wdata_q;
  assign DMEM_BE    = be_q;
  assign BUS_ERR    = bus_err_c;

  assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign load_val = (state == ST_DONE) ? load_ext : '0;

  // Next-state logic; a completing response wins over abort and timeout.
  always_comb begin
    state_nxt = state;
    cap_rdata = 1'b0;
    cap_zero  = 1'b0;
    bus_err_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc_go) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (DMEM_GNT && DMEM_RVALID) begin
          state_nxt = ST_DONE;
          cap_rdata = 1'b1;
        end else if (DE_Context_Switch) begin
          state_nxt = DMEM_GNT ? ST_DRAIN : ST_IDLE;
        end else if (tmo_hit) begin
          state_nxt = ST_DONE;
          cap_zero  = 1'b1;
          bus_err_c = 1'b1;
        end else if (DMEM_GNT) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (DMEM_RVALID) begin
          state_nxt = ST_DONE;
          cap_rdata = 1'b1;
        end else if (DE_Context_Switch) begin
          state_nxt = ST_DRAIN;
        end else if (tmo_hit) begin
          state_nxt = ST_DONE;
          cap_zero  = 1'b1;
          bus_err_c = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (DMEM_RVALID) state_nxt = ST_IDLE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, timeout counter and captured response data.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_REQ) tmo_cnt <= '0;
      else if (state == ST_REQ || state == ST_WAIT) tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (cap_rdata)     rdata_q <= DMEM_RDATA;
      else if (cap_zero) rdata_q <= '0;
    end
  end

  // Request fields are frozen at issue so the port stays stable while waiting.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else if (state == ST_IDLE && acc_go) begin
      addr_q  <= {MEM_Address[XLEN-1:OFF_W], {OFF_W{1'b0}}};
      wdata_q <= wdata_c;
      be_q    <= be_c;
      we_q    <= mem_r_w;
    end
  end

  // WB latch: loads when the stage is free, otherwise inserts a bubble.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WB_V              <= 1'b0;
      WB_PC_MUX         <= 1'b0;
      WB_Cst            <= '0;
      WB_RES            <= '0;
      WB_NPC            <= '0;
      WB_Target_Address <= '0;
      WB_IR             <= '0;
    end else if (!MEM_STALL) begin
      WB_V              <= MEM_V & ~DE_Context_Switch;
      WB_PC_MUX         <= MEM_PC_MUX;
      WB_Cst            <= MEM_Cst;
      WB_RES            <= MEM_Cst[CST_RES_MUX] ? load_val : MEM_RES;
      WB_NPC            <= MEM_NPC;
      WB_Target_Address <= MEM_Target_Address;
      WB_IR             <= MEM_IR;
    end else begin
      WB_V <= 1'b0;
    end
  end

endmodule
